student_sample_ring_tlul: RTL and testbench
===========================================

Name: student_sample_ring_tlul

Overview:
- Parametrised circular sample buffer for the FIR datapath.
- A streaming push port writes samples at an auto-incrementing, wrapping write pointer.
- A tap port reads samples by age: offset 0 is the newest sample. Taps older than the fill level read as zero, which gives zero-padding at FIR start-up.
- A TL-UL slave (tlul_adapter_sram, Outstanding=1) gives host access to the sample RAM and to control/status registers. Host accesses are arbitrated against stream traffic using gnt, not by overriding stream traffic.

Parameters:
- AddrWidth, 10, log2 of buffer depth; Depth = 2**AddrWidth.
- DataSize, 16, sample width in bits; legal range 1..32 (elaboration error otherwise).
- INIT_F, "", optional RAM init file.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- push_valid_i  in  1  sample push request.
- push_data_i  in  DataSize  sample to push.
- push_ready_o  out  1  push accepted when push_valid_i && push_ready_o.
- tap_req_i  in  1  tap read request.
- tap_offset_i  in  AddrWidth  sample age; 0 = newest.
- tap_valid_o  out  1  tap_data_o valid.
- tap_data_o  out  DataSize  tapped sample.
- fill_o  out  AddrWidth+1  samples held, saturating at Depth.
- tl_i  in  tl_h2d_t  TL-UL request.
- tl_o  out  tl_d2h_t  TL-UL response.

Behaviour:
- Reset values: wptr=0, fill=0, CTRL=0, push_ready_o=1, tap_valid_o=0, tap_data_o=0, fill_o=0, TL rvalid=0.
- RAM: dual-port. Port A handles writes (push or TL). Port B handles reads (tap or TL). Read latency is 1 cycle.
- Adapter SramAw = AddrWidth+1, SramDw = 32. Word address bit AddrWidth selects the target:
  - 0: RAM, physical index addr[AddrWidth-1:0].
  - 1: registers, decoded on addr[1:0].
- Register map:
  - 0 CTRL (RW): bit0 FREEZE, bit1 CLEAR. CLEAR is write-1 pulse and reads as 0.
  - 1 WPTR (RO).
  - 2 FILL (RO).
  - 3 OVERRUN (RO): 16-bit saturating count of cycles with push_valid_i && !push_ready_o.
  - Writes to RO registers are ignored.
- Push:
  - push_ready_o = !FREEZE && !(clear write in progress this cycle).
  - On fire: RAM[wptr] <= push_data_i; wptr <= wptr+1 (wraps Depth-1 -> 0); fill <= min(fill+1, Depth).
- Tap:
  - Physical address = (wptr - 1 - tap_offset_i) mod Depth.
  - tap_valid_o is asserted exactly 1 cycle after tap_req_i.
  - tap_data_o = RAM data if tap_offset_i < fill at the request cycle, else 0.
  - The tap sees the wptr/fill values from before any push in the same cycle.
  - Taps are never stalled.
- Arbitration:
  - gnt_i = 0 when a TL RAM write coincides with a push fire.
  - gnt_i = 0 when a TL RAM read coincides with tap_req_i.
  - gnt_i = 1 otherwise; register accesses are always granted.
  - A stalled TL request is held by the adapter and retried.
- TL RAM write:
  - Executed only if every wmask byte covering bits [DataSize-1:0] is set.
  - Otherwise the write is discarded; the response is still a normal ack with no error.
  - A TL write does not change wptr or fill.
- TL RAM read: returns the sample zero-extended to 32 bits; rvalid is asserted 1 cycle after the grant.
- Register reads: 1 cycle latency, zero-extended.
- CLEAR: wptr <= 0 and fill <= 0 on the next edge. RAM contents are kept. OVERRUN is cleared.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight TL or tap response is dropped.

Test Plan:
- Reset, push 3 samples 0x0011, 0x0022, 0x0033 -> WPTR=3, fill_o=3; tap offsets 0/1/2 return 0x0033/0x0022/0x0011 one cycle after request; offset 3 returns 0.
- Push Depth+5 samples (value = index) -> wptr=5, fill_o=Depth (saturated); tap offset 0 = Depth+4 (truncated), tap offset Depth-1 = 5.
- Set FREEZE=1 and hold push_valid_i for 4 cycles -> push_ready_o=0, OVERRUN=4, WPTR unchanged; set FREEZE=0 -> push accepted next cycle.
- TL write 0xDEAD to RAM word 7 in the same cycle as a push fire -> gnt low that cycle, write lands one cycle later; TL read of word 7 returns 0x0000DEAD; TL write with wmask byte1 clear leaves word 7 unchanged.
- tap_req_i held continuously while a TL RAM read is pending -> TL stalls and taps are unaffected; on tap_req_i deassert the TL read completes with correct data.
- Write CLEAR with 10 samples held -> next cycle WPTR=0, FILL=0, all taps return 0; CTRL reads back 0x0 (FREEZE preserved as written).

Source files
------------

// File: rtl/tlul_pkg.sv
// TileLink-UL channel structs and opcodes shared by the TL-UL slaves in this codebase.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_sample_ring_tlul.sv
// Circular FIR sample buffer: streaming push, age-indexed taps with zero padding,
// and a single-outstanding TL-UL slave for RAM and control/status access.
module student_sample_ring_tlul
  import tlul_pkg::*;
#(
  parameter int    AddrWidth = 10,
  parameter int    DataSize  = 16,
  parameter string INIT_F    = ""
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_valid_i,
  input  logic [DataSize-1:0]  push_data_i,
  output logic                 push_ready_o,
  input  logic                 tap_req_i,
  input  logic [AddrWidth-1:0] tap_offset_i,
  output logic                 tap_valid_o,
  output logic [DataSize-1:0]  tap_data_o,
  output logic [AddrWidth:0]   fill_o,
  input  tl_h2d_t              tl_i,
  output tl_d2h_t              tl_o
);

  localparam int Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth:0] FillMax = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [3:0] NeedMask = {DataSize > 24, DataSize > 16, DataSize > 8, 1'b1};

  if (DataSize < 1 || DataSize > 32) begin : g_bad_width
    $error("DataSize must be within 1..32");
  end

  logic [DataSize-1:0]  mem [Depth];
  logic [DataSize-1:0]  rdata_b;
  logic [AddrWidth-1:0] wptr_q;
  logic [AddrWidth:0]   fill_q;
  logic                 freeze_q;
  logic [15:0]          overrun_q;
  logic                 tap_valid_q, tap_hit_q;
  logic                 d_valid_q, d_is_read_q, d_ram_pend_q;
  logic [7:0]           d_source_q;
  logic [1:0]           d_size_q;
  logic [31:0]          d_data_q, reg_rdata;

  logic                 slot_free, a_req, a_write, a_reg, a_fire, gnt, mask_ok;
  logic                 push_fire, clear_wr;
  logic [AddrWidth-1:0] a_idx, tap_addr, rd_addr;
  logic [1:0]           reg_idx;
  logic                 unused_tl;

  assign slot_free = !d_valid_q || tl_i.d_ready;
  assign a_req     = tl_i.a_valid && slot_free;
  assign a_write   = tl_i.a_opcode inside {PutFullData, PutPartialData};
  assign a_reg     = tl_i.a_address[AddrWidth+2];
  assign a_idx     = tl_i.a_address[AddrWidth+1:2];
  assign reg_idx   = tl_i.a_address[3:2];
  assign mask_ok   = &(tl_i.a_mask | ~NeedMask);
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address, tl_i.a_data, tl_i.a_mask};

  // A clear write blocks the push in the same cycle so the new sample is not lost behind the reset pointer.
  assign clear_wr     = a_req && a_write && a_reg && (reg_idx == 2'd0) && tl_i.a_mask[0] && tl_i.a_data[1];
  assign push_ready_o = !freeze_q && !clear_wr;
  assign push_fire    = push_valid_i && push_ready_o;

  assign gnt    = !(a_req && !a_reg && (a_write ? push_fire : tap_req_i));
  assign a_fire = a_req && gnt;

  assign tap_addr = wptr_q - tap_offset_i - AddrWidth'(1);
  assign rd_addr  = tap_req_i ? tap_addr : a_idx;

  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem[wptr_q] <= push_data_i;
    end else if (a_fire && a_write && !a_reg && mask_ok) begin
      mem[a_idx] <= tl_i.a_data[DataSize-1:0];
    end
    rdata_b <= mem[rd_addr];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      fill_q    <= '0;
      freeze_q  <= 1'b0;
      overrun_q <= '0;
    end else begin
      if (a_fire && a_write && a_reg && (reg_idx == 2'd0) && tl_i.a_mask[0]) begin
        freeze_q <= tl_i.a_data[0];
      end
      if (clear_wr) begin
        wptr_q    <= '0;
        fill_q    <= '0;
        overrun_q <= '0;
      end else begin
        if (push_fire) begin
          wptr_q <= wptr_q + AddrWidth'(1);
          if (fill_q != FillMax) fill_q <= fill_q + (AddrWidth+1)'(1);
        end
        if (push_valid_i && !push_ready_o && (overrun_q != 16'hFFFF)) begin
          overrun_q <= overrun_q + 16'd1;
        end
      end
    end
  end

  // Fill is compared before any same-cycle push so taps line up with the pre-push pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tap_valid_q <= 1'b0;
      tap_hit_q   <= 1'b0;
    end else begin
      tap_valid_q <= tap_req_i;
      tap_hit_q   <= tap_req_i && ({1'b0, tap_offset_i} < fill_q);
    end
  end

  assign tap_valid_o = tap_valid_q;
  assign tap_data_o  = tap_hit_q ? rdata_b : '0;
  assign fill_o      = fill_q;

  always_comb begin
    reg_rdata = '0;
    case (reg_idx)
      2'd0:    reg_rdata = {31'd0, freeze_q};
      2'd1:    reg_rdata = 32'(wptr_q);
      2'd2:    reg_rdata = 32'(fill_q);
      default: reg_rdata = {16'd0, overrun_q};
    endcase
  end

  // RAM read data is only valid the cycle after the grant, so it is parked if the host stalls d_ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid_q    <= 1'b0;
      d_is_read_q  <= 1'b0;
      d_ram_pend_q <= 1'b0;
      d_source_q   <= '0;
      d_size_q     <= '0;
      d_data_q     <= '0;
    end else if (a_fire) begin
      d_valid_q    <= 1'b1;
      d_is_read_q  <= !a_write;
      d_ram_pend_q <= !a_write && !a_reg;
      d_source_q   <= tl_i.a_source;
      d_size_q     <= tl_i.a_size;
      d_data_q     <= (!a_write && a_reg) ? reg_rdata : '0;
    end else if (d_valid_q && tl_i.d_ready) begin
      d_valid_q    <= 1'b0;
      d_ram_pend_q <= 1'b0;
    end else if (d_ram_pend_q) begin
      d_data_q     <= 32'(rdata_b);
      d_ram_pend_q <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_is_read_q ? AccessAckData : AccessAck;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_ram_pend_q ? 32'(rdata_b) : d_data_q;
    tl_o.a_ready  = gnt && slot_free;
  end

endmodule

// File: tb/tb_student_sample_ring_tlul.sv
// Self-checking bench for student_sample_ring_tlul: table-driven push/tap vectors plus
// hand-written TL-UL sequences, with tap and TL responses checked through scoreboard queues.
module tb_student_sample_ring_tlul;
  import tlul_pkg::*;

  localparam int AW    = 4;
  localparam int DS    = 16;
  localparam int Depth = 2 ** AW;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          push_valid_i;
  logic [DS-1:0] push_data_i;
  logic          push_ready_o;
  logic          tap_req_i;
  logic [AW-1:0] tap_offset_i;
  logic          tap_valid_o;
  logic [DS-1:0] tap_data_o;
  logic [AW:0]   fill_o;
  tl_h2d_t       tl_i;
  tl_d2h_t       tl_o;

  always #5 clk_i = ~clk_i;

  student_sample_ring_tlul #(.AddrWidth(AW), .DataSize(DS), .INIT_F("")) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .push_valid_i(push_valid_i), .push_data_i(push_data_i), .push_ready_o(push_ready_o),
    .tap_req_i(tap_req_i), .tap_offset_i(tap_offset_i),
    .tap_valid_o(tap_valid_o), .tap_data_o(tap_data_o),
    .fill_o(fill_o), .tl_i(tl_i), .tl_o(tl_o)
  );

  typedef struct { bit is_read; logic [31:0] data; } tl_exp_t;
  typedef struct { bit pv; logic [15:0] pd; bit tr; logic [3:0] toff; int exp_fill; } vec_t;

  int            total = 0;
  int            bad = 0;
  logic [15:0]   tapq[$];
  tl_exp_t       tlq[$];
  logic [15:0]   m_mem [Depth];
  int            m_wptr, m_fill, m_overrun;
  bit            m_freeze;
  bit            last_acc;
  vec_t          vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: predict from the model, advance the model, then check the registered outputs.
  task automatic applyStimulus();
    bit a_wr, a_reg, clr, m_ready, m_gnt, acc, exp_tapv;
    int idx, ridx;
    logic [31:0] rd;
    tl_exp_t e;
    logic [15:0] t;
    #1;
    a_wr  = tl_i.a_valid && (tl_i.a_opcode != Get);
    a_reg = tl_i.a_address[AW+2];
    idx   = int'(tl_i.a_address[AW+1:2]);
    ridx  = int'(tl_i.a_address[3:2]);
    clr   = a_wr && a_reg && (ridx == 0) && tl_i.a_mask[0] && tl_i.a_data[1];
    m_ready = !m_freeze && !clr;
    checkOutput("push_ready", 32'(push_ready_o), 32'(m_ready));
    m_gnt = 1'b1;
    if (tl_i.a_valid && !a_reg) begin
      if (a_wr && push_valid_i && m_ready) m_gnt = 1'b0;
      if (!a_wr && tap_req_i) m_gnt = 1'b0;
    end
    acc = tl_i.a_valid && m_gnt;
    if (tl_i.a_valid) checkOutput("a_ready", 32'(tl_o.a_ready), 32'(m_gnt));
    if (tap_req_i)
      tapq.push_back((int'(tap_offset_i) < m_fill) ? m_mem[(m_wptr - 1 - int'(tap_offset_i)) & (Depth - 1)] : 16'h0);
    if (acc) begin
      rd = 32'h0;
      if (!a_wr) begin
        if (a_reg) begin
          case (ridx)
            0: rd = 32'(m_freeze);
            1: rd = 32'(m_wptr);
            2: rd = 32'(m_fill);
            default: rd = 32'(m_overrun);
          endcase
        end else rd = {16'h0, m_mem[idx]};
      end
      tlq.push_back('{is_read: !a_wr, data: rd});
    end
    if (push_valid_i && !m_ready && m_overrun < 65535) m_overrun++;
    if (push_valid_i && m_ready) begin
      m_mem[m_wptr] = push_data_i;
      m_wptr = (m_wptr + 1) % Depth;
      if (m_fill < Depth) m_fill++;
    end
    if (acc && a_wr) begin
      if (a_reg) begin
        if (ridx == 0 && tl_i.a_mask[0]) m_freeze = tl_i.a_data[0];
        if (clr) begin m_wptr = 0; m_fill = 0; m_overrun = 0; end
      end else if (tl_i.a_mask[1:0] == 2'b11) begin
        m_mem[idx] = tl_i.a_data[15:0];
      end
    end
    exp_tapv = tap_req_i;
    last_acc = acc;
    @(posedge clk_i); #1;
    checkOutput("tap_valid", 32'(tap_valid_o), 32'(exp_tapv));
    if (tap_valid_o) begin
      if (tapq.size() == 0) checkOutput("tap_unexpected", 32'(tap_valid_o), 32'h0);
      else begin t = tapq.pop_front(); checkOutput("tap_data", 32'(tap_data_o), 32'(t)); end
    end
    checkOutput("tl_d_valid", 32'(tl_o.d_valid), 32'(acc));
    if (tl_o.d_valid) begin
      if (tlq.size() == 0) checkOutput("tl_unexpected", 32'(tl_o.d_valid), 32'h0);
      else begin
        e = tlq.pop_front();
        checkOutput("tl_d_opcode", 32'(tl_o.d_opcode), e.is_read ? 32'(AccessAckData) : 32'(AccessAck));
        if (e.is_read) checkOutput("tl_d_data", tl_o.d_data, e.data);
      end
    end
    checkOutput("fill_o", 32'(fill_o), 32'(m_fill));
  endtask

  task automatic idle();
    push_valid_i = 1'b0;
    tap_req_i    = 1'b0;
    tl_i.a_valid = 1'b0;
  endtask

  task automatic tlDrive(input bit wr, input bit reg_sel, input int word,
                         input logic [31:0] data, input logic [3:0] mask);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = wr ? ((mask == 4'hF) ? PutFullData : PutPartialData) : Get;
    tl_i.a_address = 32'(((reg_sel ? Depth : 0) + word) * 4);
    tl_i.a_data    = data;
    tl_i.a_mask    = mask;
  endtask

  task automatic tlWait();
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if (last_acc) begin
        tl_i.a_valid = 1'b0;
        return;
      end
    end
    checkOutput("tl_grant_timeout", 32'(last_acc), 32'h1);
    tl_i.a_valid = 1'b0;
  endtask

  task automatic tlWrite(input bit reg_sel, input int word, input logic [31:0] data, input logic [3:0] mask);
    tlDrive(1'b1, reg_sel, word, data, mask);
    tlWait();
  endtask

  task automatic tlRead(input bit reg_sel, input int word);
    tlDrive(1'b0, reg_sel, word, 32'h0, 4'hF);
    tlWait();
  endtask

  task automatic doReset();
    idle();
    rst_ni = 1'b0;
    #3;
    checkOutput("rst_push_ready", 32'(push_ready_o), 32'h1);
    checkOutput("rst_tap_valid", 32'(tap_valid_o), 32'h0);
    checkOutput("rst_tap_data", 32'(tap_data_o), 32'h0);
    checkOutput("rst_fill", 32'(fill_o), 32'h0);
    checkOutput("rst_tl_d_valid", 32'(tl_o.d_valid), 32'h0);
    m_wptr = 0; m_fill = 0; m_overrun = 0; m_freeze = 1'b0;
    tapq.delete();
    tlq.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic push(input logic [15:0] d);
    push_valid_i = 1'b1;
    push_data_i  = d;
    applyStimulus();
    push_valid_i = 1'b0;
  endtask

  task automatic tap(input int off);
    tap_req_i    = 1'b1;
    tap_offset_i = AW'(off);
    applyStimulus();
    tap_req_i    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1, 16'h0011, 0, 4'd0, 1};
    vecs[1] = '{1, 16'h0022, 0, 4'd0, 2};
    vecs[2] = '{1, 16'h0033, 0, 4'd0, 3};
    vecs[3] = '{0, 16'h0000, 1, 4'd0, 3};
    vecs[4] = '{0, 16'h0000, 1, 4'd1, 3};
    vecs[5] = '{0, 16'h0000, 1, 4'd2, 3};
    vecs[6] = '{0, 16'h0000, 1, 4'd3, 3};
    vecs[7] = '{1, 16'h0044, 1, 4'd0, 4};
    vecs[8] = '{0, 16'h0000, 1, 4'd0, 4};

    tl_i = '0;
    tl_i.d_ready = 1'b1;
    push_data_i  = '0;
    tap_offset_i = '0;
    idle();
    doReset();

    $display("[TB] push/tap vector table");
    for (int i = 0; i < 9; i++) begin
      push_valid_i = vecs[i].pv;
      push_data_i  = vecs[i].pd;
      tap_req_i    = vecs[i].tr;
      tap_offset_i = vecs[i].toff;
      applyStimulus();
      checkOutput("vec_fill", 32'(fill_o), 32'(vecs[i].exp_fill));
    end
    idle();
    tlRead(1'b1, 1);

    $display("[TB] wrap and fill saturation");
    doReset();
    for (int i = 0; i < Depth + 5; i++) push(16'(i));
    applyStimulus();
    checkOutput("fill_saturated", 32'(fill_o), 32'(Depth));
    tap(0);
    tap(Depth - 1);
    tlRead(1'b1, 1);
    tlRead(1'b1, 2);

    $display("[TB] freeze and overrun");
    tlWrite(1'b1, 0, 32'h1, 4'hF);
    push_valid_i = 1'b1;
    push_data_i  = 16'hAAAA;
    for (int i = 0; i < 4; i++) applyStimulus();
    push_valid_i = 1'b0;
    tlRead(1'b1, 3);
    tlRead(1'b1, 1);
    tlWrite(1'b1, 0, 32'h0, 4'hF);
    push(16'h0100);
    tlRead(1'b1, 1);

    $display("[TB] TL write arbitration against push");
    tlDrive(1'b1, 1'b0, 7, 32'h0000DEAD, 4'hF);
    push_valid_i = 1'b1;
    push_data_i  = 16'h0200;
    applyStimulus();
    push_valid_i = 1'b0;
    tlWait();
    tlRead(1'b0, 7);
    tlWrite(1'b0, 7, 32'h0000BEEF, 4'b1101);
    tlRead(1'b0, 7);
    checkOutput("fill_after_tl_write", 32'(fill_o), 32'(Depth));

    $display("[TB] TL read stalled by continuous taps");
    tlDrive(1'b0, 1'b0, 7, 32'h0, 4'hF);
    tap_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tap_offset_i = AW'(i);
      applyStimulus();
    end
    tap_req_i = 1'b0;
    tlWait();

    $display("[TB] clear with samples held");
    doReset();
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    push_valid_i = 1'b1;
    push_data_i  = 16'h0FFF;
    tlWrite(1'b1, 0, 32'h2, 4'hF);
    push_valid_i = 1'b0;
    checkOutput("fill_after_clear", 32'(fill_o), 32'h0);
    tlRead(1'b1, 1);
    tlRead(1'b1, 2);
    tlRead(1'b1, 3);
    tlRead(1'b1, 0);
    for (int i = 0; i < 4; i++) tap(i);
    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
